// File: rtl/pipe_defs.sv
// Shared pipeline definitions so the forwarding unit, register file and hazard
// logic agree on register addressing and multiplier latency.
package pipe_defs;

    localparam int REG_W       = 4;
    localparam int MUL_LAT_DEF = 4;

    localparam logic [REG_W-1:0] REG_ZERO = 4'd0;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_t;

endpackage

// File: rtl/hazard_unit_mul_sequencer.sv
// Countdown sequencer for the single in-flight multi-cycle multiply: tracks busy,
// emits the one-cycle done pulse and latches the destination register.
module mul_sequencer
    import pipe_defs::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [REG_W-1:0] dest_in,
    output logic             busy,
    output logic             done,
    output logic [REG_W-1:0] dest
);

    mul_state_t       state;
    logic [CNT_W-1:0] count;

    // The done cycle is spent in IDLE, so a new start is accepted alongside done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MUL_IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            dest  <= REG_ZERO;
        end else begin
            done <= 1'b0;
            case (state)
                MUL_IDLE: begin
                    if (start) begin
                        state <= MUL_BUSY;
                        count <= CNT_W'(MUL_LAT);
                        busy  <= 1'b1;
                        dest  <= dest_in;
                    end
                end
                MUL_BUSY: begin
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        state <= MUL_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= MUL_IDLE;
                    count <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// ID-stage hazard detection: stalls the front end on load-use and multiply
// conflicts that forwarding cannot cover, and launches the multiplier.
module hazard_unit
    import pipe_defs::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int CNT_W   = 4,
    parameter int PERF_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  ifid_rs,
    input  logic [REG_W-1:0]  ifid_rt,
    input  logic              ifid_rs_used,
    input  logic              ifid_rt_used,
    input  logic [REG_W-1:0]  ifid_dest,
    input  logic              ifid_writes,
    input  logic              ifid_is_mul,
    input  logic [REG_W-1:0]  idex_dest,
    input  logic              idex_writes,
    input  logic              idex_is_load,
    output logic              stall,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_bubble,
    output logic              mul_start,
    output logic              mul_busy,
    output logic [REG_W-1:0]  mul_dest,
    output logic              mul_done,
    output logic [PERF_W-1:0] stall_count
);

    function automatic logic rd_match(
        input logic [REG_W-1:0] r,
        input logic [REG_W-1:0] rs,
        input logic             rs_used,
        input logic [REG_W-1:0] rt,
        input logic             rt_used
    );
        return (r != REG_ZERO) &&
               ((rs_used && (rs == r)) || (rt_used && (rt == r)));
    endfunction

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (v == {PERF_W{1'b1}}) ? v : v + PERF_W'(1);
    endfunction

    logic load_use;
    logic mul_raw;
    logic mul_waw;
    logic mul_hz;

    assign load_use = idex_is_load && idex_writes &&
                      rd_match(idex_dest, ifid_rs, ifid_rs_used, ifid_rt, ifid_rt_used);

    // RAW, WAW and structural (second multiply) conflicts against the in-flight multiply.
    assign mul_raw = rd_match(mul_dest, ifid_rs, ifid_rs_used, ifid_rt, ifid_rt_used);
    assign mul_waw = ifid_writes && (ifid_dest == mul_dest) && (mul_dest != REG_ZERO);
    assign mul_hz  = mul_busy && (mul_raw || mul_waw || ifid_is_mul);

    assign stall       = load_use || mul_hz;
    assign pc_write    = ~stall;
    assign ifid_write  = ~stall;
    assign idex_bubble = stall;
    assign mul_start   = ifid_is_mul && !stall;

    mul_sequencer #(
        .MUL_LAT (MUL_LAT),
        .CNT_W   (CNT_W)
    ) u_mul_seq (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .dest_in (ifid_dest),
        .busy    (mul_busy),
        .done    (mul_done),
        .dest    (mul_dest)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall) begin
            stall_count <= sat_inc(stall_count);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed scoreboard bench for hazard_unit: load-use, register zero, multiply
// timing and conflicts, back-to-back issue, reset abandon, counter saturation.
module tb_hazard_unit;

    localparam int PERF_W = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  ifid_rs = '0;
    logic [3:0]  ifid_rt = '0;
    logic        ifid_rs_used = 1'b0;
    logic        ifid_rt_used = 1'b0;
    logic [3:0]  ifid_dest = '0;
    logic        ifid_writes = 1'b0;
    logic        ifid_is_mul = 1'b0;
    logic [3:0]  idex_dest = '0;
    logic        idex_writes = 1'b0;
    logic        idex_is_load = 1'b0;
    logic        stall;
    logic        pc_write;
    logic        ifid_write;
    logic        idex_bubble;
    logic        mul_start;
    logic        mul_busy;
    logic [3:0]  mul_dest;
    logic        mul_done;
    logic [PERF_W-1:0] stall_count;

    hazard_unit #(.MUL_LAT(4), .CNT_W(4), .PERF_W(PERF_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .ifid_rs_used (ifid_rs_used),
        .ifid_rt_used (ifid_rt_used),
        .ifid_dest    (ifid_dest),
        .ifid_writes  (ifid_writes),
        .ifid_is_mul  (ifid_is_mul),
        .idex_dest    (idex_dest),
        .idex_writes  (idex_writes),
        .idex_is_load (idex_is_load),
        .stall        (stall),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .idex_bubble  (idex_bubble),
        .mul_start    (mul_start),
        .mul_busy     (mul_busy),
        .mul_dest     (mul_dest),
        .mul_done     (mul_done),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    localparam int F_STALL = 0, F_PCW = 1, F_IFIDW = 2, F_BUB = 3, F_START = 4,
                   F_BUSY = 5, F_DONE = 6, F_DEST = 7, F_CNT = 8;

    typedef struct {
        string       tag;
        int          fld;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic [PERF_W-1:0] sc = '0;

    function automatic logic [31:0] observe(input int f);
        case (f)
            F_STALL: return {31'd0, stall};
            F_PCW:   return {31'd0, pc_write};
            F_IFIDW: return {31'd0, ifid_write};
            F_BUB:   return {31'd0, idex_bubble};
            F_START: return {31'd0, mul_start};
            F_BUSY:  return {31'd0, mul_busy};
            F_DONE:  return {31'd0, mul_done};
            F_DEST:  return {28'd0, mul_dest};
            F_CNT:   return {16'd0, stall_count};
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic push(input string tag, input int fld, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.fld = fld;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.fld);
            vectors++;
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    // Pushes the stall-derived controls plus the counter value seen this cycle.
    task automatic exp_stall(input string tag, input logic st);
        push({tag, ".stall"}, F_STALL, {31'd0, st});
        push({tag, ".pc_write"}, F_PCW, {31'd0, ~st});
        push({tag, ".ifid_write"}, F_IFIDW, {31'd0, ~st});
        push({tag, ".bubble"}, F_BUB, {31'd0, st});
        push({tag, ".stall_count"}, F_CNT, {16'd0, sc});
        if (st && sc != {PERF_W{1'b1}}) sc = sc + 1'b1;
    endtask

    task automatic exp_mul(input string tag, input logic st, input logic bz,
                           input logic dn, input logic [3:0] dst);
        push({tag, ".mul_start"}, F_START, {31'd0, st});
        push({tag, ".mul_busy"}, F_BUSY, {31'd0, bz});
        push({tag, ".mul_done"}, F_DONE, {31'd0, dn});
        push({tag, ".mul_dest"}, F_DEST, {28'd0, dst});
    endtask

    task automatic clr_in();
        ifid_rs = '0; ifid_rt = '0; ifid_rs_used = 1'b0; ifid_rt_used = 1'b0;
        ifid_dest = '0; ifid_writes = 1'b0; ifid_is_mul = 1'b0;
        idex_dest = '0; idex_writes = 1'b0; idex_is_load = 1'b0;
    endtask

    // Inputs are set at posedge+1; outputs are checked at the falling edge.
    task automatic cyc();
        #4;
        drain();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_mul(input logic [3:0] d);
        ifid_is_mul = 1'b1;
        ifid_writes = 1'b1;
        ifid_dest   = d;
    endtask

    initial begin
        clr_in();
        @(posedge clk);
        #1;
        exp_stall("reset", 1'b0);
        exp_mul("reset", 1'b0, 1'b0, 1'b0, 4'd0);
        #3;
        drain();
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Load-use on rs
        idex_is_load = 1'b1; idex_writes = 1'b1; idex_dest = 4'd5;
        ifid_rs = 4'd5; ifid_rs_used = 1'b1;
        exp_stall("lu_rs", 1'b1);
        cyc();
        idex_is_load = 1'b0;
        exp_stall("lu_clear", 1'b0);
        cyc();

        // Register zero and unused-operand cases
        idex_is_load = 1'b1; idex_writes = 1'b1; idex_dest = 4'd0;
        ifid_rs = 4'd0; ifid_rs_used = 1'b1;
        exp_stall("r0", 1'b0);
        cyc();
        idex_dest = 4'd6; ifid_rs = 4'd2; ifid_rt = 4'd6; ifid_rt_used = 1'b0;
        exp_stall("rt_unused", 1'b0);
        cyc();
        ifid_rt_used = 1'b1;
        exp_stall("lu_rt", 1'b1);
        cyc();
        idex_writes = 1'b0;
        exp_stall("load_no_write", 1'b0);
        cyc();

        // Multiply timing and conflicts while busy
        clr_in();
        issue_mul(4'd7);
        exp_mul("mul0", 1'b1, 1'b0, 1'b0, 4'd0);
        exp_stall("mul0", 1'b0);
        cyc();
        clr_in();
        ifid_rs = 4'd7; ifid_rs_used = 1'b1;
        exp_mul("busy1_raw", 1'b0, 1'b1, 1'b0, 4'd7);
        exp_stall("busy1_raw", 1'b1);
        cyc();
        clr_in();
        ifid_writes = 1'b1; ifid_dest = 4'd7;
        exp_mul("busy2_waw", 1'b0, 1'b1, 1'b0, 4'd7);
        exp_stall("busy2_waw", 1'b1);
        cyc();
        clr_in();
        issue_mul(4'd2);
        exp_mul("busy3_struct", 1'b0, 1'b1, 1'b0, 4'd7);
        exp_stall("busy3_struct", 1'b1);
        cyc();
        clr_in();
        ifid_rs = 4'd3; ifid_rs_used = 1'b1;
        exp_mul("busy4_indep", 1'b0, 1'b1, 1'b0, 4'd7);
        exp_stall("busy4_indep", 1'b0);
        cyc();
        ifid_rs = 4'd7;
        exp_mul("done_reader", 1'b0, 1'b0, 1'b1, 4'd7);
        exp_stall("done_reader", 1'b0);
        cyc();
        clr_in();
        exp_mul("after_done", 1'b0, 1'b0, 1'b0, 4'd7);
        cyc();

        // Back-to-back multiply: second issues on the done cycle
        issue_mul(4'd7);
        exp_mul("b2b0", 1'b1, 1'b0, 1'b0, 4'd7);
        cyc();
        issue_mul(4'd9);
        for (int i = 1; i <= 4; i++) begin
            exp_mul($sformatf("b2b_wait%0d", i), 1'b0, 1'b1, 1'b0, 4'd7);
            exp_stall($sformatf("b2b_wait%0d", i), 1'b1);
            cyc();
        end
        exp_mul("b2b_done_start", 1'b1, 1'b0, 1'b1, 4'd7);
        exp_stall("b2b_done_start", 1'b0);
        cyc();
        clr_in();
        for (int i = 1; i <= 4; i++) begin
            exp_mul($sformatf("b2b_busy%0d", i), 1'b0, 1'b1, 1'b0, 4'd9);
            cyc();
        end
        exp_mul("b2b_done2", 1'b0, 1'b0, 1'b1, 4'd9);
        cyc();

        // Reset during busy cycle 2 abandons the multiply
        issue_mul(4'd4);
        exp_mul("rm0", 1'b1, 1'b0, 1'b0, 4'd9);
        cyc();
        clr_in();
        exp_mul("rm1", 1'b0, 1'b1, 1'b0, 4'd4);
        cyc();
        push("rm2.busy", F_BUSY, 32'd1);
        #1;
        drain();
        rst = 1'b1;
        #1;
        sc = '0;
        exp_mul("rm_async", 1'b0, 1'b0, 1'b0, 4'd0);
        exp_stall("rm_async", 1'b0);
        drain();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push($sformatf("rm_after%0d.done", i), F_DONE, 32'd0);
            push($sformatf("rm_after%0d.busy", i), F_BUSY, 32'd0);
            cyc();
        end

        // Stall-counter saturation
        idex_is_load = 1'b1; idex_writes = 1'b1; idex_dest = 4'd5;
        ifid_rs = 4'd5; ifid_rs_used = 1'b1;
        repeat ((1 << PERF_W) + 3) @(posedge clk);
        #1;
        sc = {PERF_W{1'b1}};
        exp_stall("saturate", 1'b1);
        cyc();
        exp_stall("saturate_hold", 1'b1);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Producer-side partner of the EX-stage operand forwarding unit. The forwarding unit selects bypassed results for consumers; this block decides when bypassing cannot cover a dependency and stalls the front end.
- Detects load-use hazards and tracks one in-flight multi-cycle multiply. It emits PC/IF-ID hold and ID/EX bubble controls, and sequences the multiplier start/done handshake.
- Sits in the ID stage beside the register file.

Parameters:
- MUL_LAT, 4, multiply latency in cycles from mul_start to mul_done (legal 2..15).
- CNT_W, 4, width of the multiply countdown counter.
- PERF_W, 16, width of the saturating stall-cycle performance counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ifid_rs  in  4  source register 1 of the instruction in ID
- ifid_rt  in  4  source register 2 of the instruction in ID
- ifid_rs_used  in  1  ID instruction reads rs
- ifid_rt_used  in  1  ID instruction reads rt
- ifid_dest  in  4  destination register of the ID instruction
- ifid_writes  in  1  ID instruction writes a register
- ifid_is_mul  in  1  ID instruction is a multiply
- idex_dest  in  4  destination register of the instruction in EX
- idex_writes  in  1  EX instruction writes a register
- idex_is_load  in  1  EX instruction is a load
- stall  out  1  hazard present this cycle
- pc_write  out  1  PC update enable (equals ~stall)
- ifid_write  out  1  IF/ID register enable (equals ~stall)
- idex_bubble  out  1  insert NOP into ID/EX (equals stall)
- mul_start  out  1  one-cycle pulse that launches the multiplier
- mul_busy  out  1  multiply in flight
- mul_dest  out  4  latched destination register of the in-flight or just-completed multiply
- mul_done  out  1  one-cycle pulse; multiplier result is written to mul_dest via the RF second write port
- stall_count  out  PERF_W  saturating count of stall cycles

Behaviour:
- Reset values (asynchronous): countdown 0, mul_busy 0, mul_done 0, mul_dest 0, stall_count 0. Combinational outputs then read pc_write=1, ifid_write=1, stall=0, idex_bubble=0.
- Register 0 never creates a hazard; any match on address 0 is ignored.
- rd_match(r) = (ifid_rs_used && ifid_rs==r) || (ifid_rt_used && ifid_rt==r), with r != 0.
- load_use = idex_is_load && idex_writes && rd_match(idex_dest).
- mul_hz = mul_busy && (rd_match(mul_dest) || (ifid_writes && ifid_dest==mul_dest && mul_dest!=0) || ifid_is_mul).
  - The three terms cover RAW, WAW and structural conflicts respectively.
- stall = load_use || mul_hz. It is combinational from the inputs and the current state, with zero latency.
- mul_start = ifid_is_mul && !stall. It is combinational.
- Countdown FSM, two states:
  - IDLE (count==0, mul_busy=0). On mul_start: count<=MUL_LAT, mul_dest<=ifid_dest, go to BUSY.
  - BUSY (count!=0, mul_busy=1). Decrement count each cycle.
  - When count==1: next cycle count=0 and mul_done=1 for exactly one cycle.
  - mul_busy is 1 for exactly MUL_LAT cycles after the start edge.
- Done cycle: mul_busy=0, so a dependent reader in ID does not stall.
  - The register file is write-first, so that reader obtains the result.
  - A new multiply may issue in the same cycle: mul_done and mul_start are both 1, and mul_dest updates at the following edge.
- mul_dest holds its value through the done cycle and until the next mul_start.
- While stalled, the ID instruction is held, so hazard evaluation repeats each cycle until it clears.
- If load_use and mul_hz are both true, there is a single stall; stall_count increments by 1.
- stall_count increments on every cycle where stall=1 and saturates at all-ones (no wrap).
- Reset asserted mid-multiply abandons the operation: no mul_done is produced and busy clears immediately.

Decomposition:
- Shared pipeline package (pipe_defs): REG_W=4, REG_ZERO=4'd0, and the MUL_LAT default, so the forwarding unit, register file and this block agree.
- One natural sub-module: mul_sequencer. It contains the countdown, busy, done and dest latch, with inputs start/dest_in.
- Hazard comparators and the performance counter stay in the top level.

Test Plan:
- Load-use: idex_is_load=1, idex_writes=1, idex_dest=5, ifid_rs=5, rs_used=1 -> stall=1, pc_write=0, idex_bubble=1 for one cycle. Dropping idex_is_load next cycle -> stall=0, and stall_count=1.
- Register zero: same as load-use but dest=0, rs=0 -> stall stays 0. Also rt match with rt_used=0 -> stall 0.
- Multiply timing (MUL_LAT=4): mul at cycle 0 with dest=7 -> mul_start=1 at cycle 0. mul_busy high for cycles 1-4. mul_done=1 at cycle 5 with mul_dest=7.
- Multiply RAW/WAW/structural: during busy, ID reads r7 -> stall. ID writes r7 -> stall. ID mul -> stall. ID reads r3 -> no stall. In the done cycle, a reader of r7 does not stall.
- Back-to-back multiply: second mul waiting in ID issues on the done cycle -> mul_done and mul_start both 1 in that cycle. New mul_dest appears the next cycle, and busy lasts another 4 cycles.
- Reset mid-operation and saturation:
  - rst asserted at busy cycle 2 -> mul_busy=0 immediately, no mul_done afterwards, stall_count=0.
  - Forcing stall for 2^PERF_W+3 cycles -> stall_count=all-ones.
